// File: rtl/pattern_count_pkg.sv
// pattern_count_pkg
//   Shared definitions for the "1010" pattern counter:
//   - default WIDTH / LEN_W / CNT_W constants
//   - sequencer state encoding (ctrl_state_e)
//   - serial detector state encoding (det_state_e)
package pattern_count_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_LEN_W = 5;
  localparam int DEF_CNT_W = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } ctrl_state_e;

  // S0: nothing useful seen, S1: "1", S2: "10", S3: "101", S4: "1010" (match)
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } det_state_e;

endpackage

// File: rtl/seq_1010_detect.sv
// seq_1010_detect
//   Moore detector for the serial pattern "1010", overlapping matches allowed.
//   match is high for exactly the cycle after the final '0' is clocked in.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset, forces S0
//   cin        serial input bit, sampled on posedge clk
//   match      high while the detector sits in S4
//   state_dbg  current detector state, for observation
module seq_1010_detect
  import pattern_count_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cin,
  output logic       match,
  output det_state_e state_dbg
);

  det_state_e state_q;
  det_state_e state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S0:      state_d = cin ? S1 : S0;
      S1:      state_d = cin ? S1 : S2;
      S2:      state_d = cin ? S3 : S0;
      S3:      state_d = cin ? S1 : S4;
      // After "1010" the trailing "10" is reused: a '1' is already "101".
      S4:      state_d = cin ? S3 : S0;
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S0;
    else     state_q <= state_d;
  end

  assign match     = (state_q == S4);
  assign state_dbg = state_q;

endmodule

// File: rtl/pattern_count_ctrl.sv
// pattern_count_ctrl
//   Scans the low N bits of a captured word MSB-first through a serial
//   "1010" detector and reports the number of overlapping matches.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      job request, only looked at in IDLE
//   abort      cancels a job in CLEAR/SHIFT/DRAIN
//   data_in    word to scan, captured when start is accepted
//   len        scan length (0 or >WIDTH means WIDTH), captured with data_in
//   busy       high in every state except IDLE
//   done       one-cycle pulse, match_cnt is final in that cycle
//   match_cnt  match count of the last completed job
// Handshake: start is accepted on the first edge at which the sequencer is
//   IDLE and start=1; busy rises the next cycle. Exactly one done pulse ends
//   an accepted job unless it is aborted or reset. start while busy is ignored.
module pattern_count_ctrl
  import pattern_count_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  ctrl_state_e      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             det_rst;
  logic             det_match;
  det_state_e       det_state;
  logic [LEN_W-1:0] n_eff;
  logic [LEN_W-1:0] align_sh;
  logic [CNT_W-1:0] cnt_inc;

  // Detector is cleared for the whole CLEAR cycle and on any abort so a
  // partial pattern from an earlier job can never leak into the next one.
  assign det_rst = rst | (state_q == CLEAR) | abort;

  seq_1010_detect u_det (
    .clk       (clk),
    .rst       (det_rst),
    .cin       (shift_q[WIDTH-1]),
    .match     (det_match),
    .state_dbg (det_state)
  );

  // Effective length and the shift that left-aligns bit N-1 into the MSB.
  assign n_eff    = ((len == '0) || (len > WIDTH_L)) ? WIDTH_L : len;
  assign align_sh = WIDTH_L - n_eff;

  always_comb begin
    cnt_inc = cnt_q;
    if (det_match && ((state_q == SHIFT) || (state_q == DRAIN)) && (cnt_q != '1))
      cnt_inc = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    cnt_d       = cnt_inc;
    match_cnt_d = match_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = data_in << align_sh;
          bit_cnt_d = n_eff;
          cnt_d     = '0;
          state_d   = CLEAR;
        end
      end
      CLEAR: state_d = SHIFT;
      SHIFT: begin
        shift_d   = shift_q << 1;
        bit_cnt_d = bit_cnt_q - LEN_W'(1);
        if (bit_cnt_q == LEN_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        // Includes a match completed by the final bit (seen this cycle).
        match_cnt_d = cnt_inc;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && ((state_q == CLEAR) || (state_q == SHIFT) || (state_q == DRAIN))) begin
      state_d     = IDLE;
      match_cnt_d = match_cnt_q;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      cnt_q       <= '0;
      match_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      cnt_q       <= cnt_d;
      match_cnt_q <= match_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_pattern_count_ctrl.sv
// tb_pattern_count_ctrl
//   Directed and random jobs for pattern_count_ctrl, checked against a
//   string-search reference of "1010" occurrences in the scanned bits.
module tb_pattern_count_ctrl;

  localparam int WIDTH = 16;
  localparam int LEN_W = 5;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] data_in;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_cnt;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] last_cnt;

  pattern_count_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .data_in   (data_in),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .match_cnt (match_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int ref_n(input logic [LEN_W-1:0] l);
    return ((l == 0) || (int'(l) > WIDTH)) ? WIDTH : int'(l);
  endfunction

  function automatic logic [CNT_W-1:0] ref_count(input logic [WIDTH-1:0] d,
                                                 input logic [LEN_W-1:0] l);
    int n;
    int hits;
    bit b[$];
    n = ref_n(l);
    hits = 0;
    for (int i = n - 1; i >= 0; i--) b.push_back(d[i]);
    for (int i = 0; i + 3 < b.size(); i++)
      if (b[i] && !b[i+1] && b[i+2] && !b[i+3]) hits++;
    if (hits > (1 << CNT_W) - 1) hits = (1 << CNT_W) - 1;
    return CNT_W'(hits);
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp)
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Presents one job and follows it to done, abort or reset.
  // inj_start/abort_at/rst_at: cycle (counted from 1 after acceptance) in
  // which that input is pulsed; 0 means never. abort_with_start asserts
  // abort alongside start in IDLE.
  task automatic run_job(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l,
                         input int inj_start, input int abort_at, input int rst_at,
                         input bit abort_with_start);
    int c;
    int n;
    int late_done;
    bit seen_done;
    bit interrupted;
    logic [CNT_W-1:0] exp;

    n = ref_n(l);
    exp_q.push_back(ref_count(d, l));
    start   = 1'b1;
    abort   = abort_with_start;
    data_in = d;
    len     = l;
    @(posedge clk); #1;
    start   = 1'b0;
    abort   = 1'b0;
    data_in = 16'($urandom);
    len     = 5'($urandom);
    c = 1;
    check("busy_rise", busy, 1'b1);
    check("cnt_hold_midjob", match_cnt, last_cnt);

    seen_done   = 0;
    interrupted = 0;
    while (c < 40) begin
      if (rst_at != 0 && c == rst_at + 1) begin
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cnt", match_cnt, 0);
        interrupted = 1;
        last_cnt = '0;
        break;
      end
      if (abort_at != 0 && c == abort_at + 1) begin
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_cnt", match_cnt, last_cnt);
        interrupted = 1;
        break;
      end
      if (done) begin
        seen_done = 1;
        break;
      end
      start = (c == inj_start);
      if (c == inj_start) begin
        data_in = '0;
        len     = '0;
      end
      abort = (c == abort_at);
      rst   = (c == rst_at);
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
      c++;
    end

    if (interrupted) begin
      void'(exp_q.pop_back());
      late_done = 0;
      for (int k = 0; k < 25; k++) begin
        if (done) late_done++;
        @(posedge clk); #1;
      end
      check("no_done_after_cut", late_done, 0);
      check("idle_after_cut", busy, 1'b0);
    end else begin
      check("done_seen", seen_done, 1'b1);
      check("done_latency", c, n + 3);
      check("busy_in_done", busy, 1'b1);
      exp = exp_q.pop_front();
      check("match_cnt", match_cnt, exp);
      last_cnt = exp;
      @(posedge clk); #1;
      check("done_one_cycle", done, 1'b0);
      check("idle_after_done", busy, 1'b0);
      check("cnt_stable", match_cnt, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    data_in  = '0;
    len      = '0;
    last_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_cnt", match_cnt, 0);
    rst = 1'b0;

    // abort in IDLE has no effect
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("idle_abort_busy", busy, 1'b0);

    run_job(16'h000A, 5'd4,  0, 0, 0, 0);
    run_job(16'hAAAA, 5'd16, 0, 0, 0, 0);
    run_job(16'h5555, 5'd16, 0, 0, 0, 0);
    run_job(16'h0005, 5'd3,  0, 0, 0, 0);
    run_job(16'hA000, 5'd0,  0, 0, 0, 0);
    run_job(16'hA000, 5'd31, 0, 0, 0, 0);
    // start while busy ignored, then abort in SHIFT
    run_job(16'hAAAA, 5'd16, 5, 0, 0, 0);
    run_job(16'hAAAA, 5'd16, 0, 6, 0, 0);
    // abort in CLEAR and in DRAIN
    run_job(16'h5555, 5'd8,  0, 1, 0, 0);
    run_job(16'h000A, 5'd4,  0, 6, 0, 0);
    // start together with abort in IDLE: start wins
    run_job(16'h0A0A, 5'd12, 0, 0, 0, 1);
    // reset mid-job, then a clean job
    run_job(16'hAAAA, 5'd16, 0, 0, 8, 0);
    run_job(16'h000A, 5'd4,  0, 0, 0, 0);

    for (int i = 0; i < 12; i++)
      run_job(16'($urandom), 5'($urandom_range(0, 31)), 0, 0, 0, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/pattern_count_ctrl.md
Name: pattern_count_ctrl

Overview:
Sequencer that scans a parallel word bit-serially through a Moore "1010" sequence detector. It counts overlapping matches and reports the total with a one-cycle done pulse. It sits between a host that issues start/len/data commands and the serial detector datapath, which it instantiates and clears per job.

Parameters:
WIDTH, 16, bits in data_in; maximum scan length.
LEN_W, 5, width of len; must satisfy 2**LEN_W > WIDTH.
CNT_W, 5, width of match_cnt; the count saturates at all-ones.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
start  input  1  job request; sampled only in IDLE.
abort  input  1  cancel the running job.
data_in  input  WIDTH  word to scan; captured when start is accepted.
len  input  LEN_W  number of bits to scan; captured with data_in.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse when match_cnt is final.
match_cnt  output  CNT_W  match count of the last completed job.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, busy=0, done=0, match_cnt=0, shift register=0. The detector is also held in its idle state.
- rst mid-job: all of the above apply on the next edge. No done pulse is issued.
- Scan length: effective length N = len. If len==0 or len>WIDTH, N = WIDTH.
- Bit order: data_in[N-1] first, down to data_in[0]. Bits above N-1 are ignored.
- Capture: on acceptance the word is left-aligned into the shift register (data_in << (WIDTH-N)). The register shifts left one bit per SHIFT cycle, and its MSB drives the detector's serial input.
- Detector: Moore machine for serial "1010" with overlap. After a match, a following "10" is another match. Its match output is high for exactly the cycle after the final '0' is clocked in.
  - Detector reset = rst | (state==CLEAR) | abort.
- State IDLE: busy=0.
  - start=1 → capture data_in/len, clear the internal count to 0, go to CLEAR.
- State CLEAR: one cycle; holds the detector in its idle state. → SHIFT, with bit counter = N.
- State SHIFT: one bit clocked into the detector per cycle; the bit counter decrements.
  - When the counter reaches 1 (last bit presented) → DRAIN.
- State DRAIN: one cycle, so a match completed by the final bit is still counted. → DONE.
- State DONE: done=1 for this one cycle. match_cnt updates from the internal count on the same edge that enters DONE. → IDLE.
- Counting: internal count increments when the detector match output is 1 and state ∈ {SHIFT, DRAIN}. It saturates at 2**CNT_W-1.
- Latency: start sampled at edge 0 → done high in cycle N+3. With N=16, done is high 19 cycles after start. The next start is accepted in the cycle after done.
- start while busy: ignored. The captured data/len are not disturbed.
- abort: honoured in CLEAR/SHIFT/DRAIN. Next state is IDLE, no done pulse, match_cnt keeps its previous value.
  - abort in IDLE or DONE has no effect. If abort and start arrive together in IDLE, start wins.
- match_cnt: stable between done pulses. It is never updated mid-job.

Decomposition:
- Shared package pattern_count_pkg:
  - state enum (IDLE, CLEAR, SHIFT, DRAIN, DONE), 3-bit encoding.
  - default WIDTH/LEN_W/CNT_W constants.
  - detector state encoding S0..S4.
- One sub-module, seq_1010_detect (clk, rst, cin → match). It is the Moore detector, instantiated once. Everything else stays in pattern_count_ctrl.

Test Plan:
- data_in=16'h000A, len=4 (bits 1010) → busy rises the cycle after start, done pulse 7 cycles after start, match_cnt=1.
- data_in=16'hAAAA, len=16 → match_cnt=7 (overlap check), done 19 cycles after start.
- data_in=16'h5555, len=16 → match_cnt=6. Then data_in=16'h0005, len=3 → match_cnt=0.
- data_in=16'hA000, len=0 → treated as 16, match_cnt=1. Then len=31 with the same data → match_cnt=1.
- Run 16'hAAAA/16. Pulse start with 16'h0000 in SHIFT → ignored, final match_cnt=7. Next job: assert abort in cycle 6 → busy=0 next cycle, no done, match_cnt still 7.
- Start 16'hAAAA/16, assert rst in cycle 8 → next cycle busy=0, done=0, match_cnt=0. A following 16'h000A/4 job gives match_cnt=1 (detector cleanly reset).
